// File: rtl/operand_pair_adder.sv
// operand_pair_adder: pairs streamed operands into A/B, adds with optional chained carry,
// and holds the sum, carry-out and reduction flags for a valid/ready consumer
module operand_pair_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_chain,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam logic [1:0] GET_A = 2'd0, GET_B = 2'd1, ADD = 2'd2, RESULT = 2'd3;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic chain_q, carry_q, cout_q, and_q, or_q, xor_q;
  logic [WIDTH:0] total;
  logic in_xfer, out_xfer;
  assign in_ready  = state_q == GET_A || state_q == GET_B;
  assign out_valid = state_q == RESULT;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign total     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, chain_q & carry_q};
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_and   = and_q;
  assign out_or    = or_q;
  assign out_xor   = xor_q;
  always_comb begin
    state_d = state_q == ADD    ? RESULT :
              state_q == RESULT ? (out_xfer ? GET_A : RESULT) :
              in_xfer           ? (state_q == GET_A ? GET_B : ADD) : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      chain_q <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      and_q   <= 1'b0;
      or_q    <= 1'b0;
      xor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_xfer && state_q == GET_A) begin
        a_q     <= in_data;
        chain_q <= in_chain;
      end
      if (in_xfer && state_q == GET_B) b_q <= in_data;
      // a pair without chaining still leaves its own carry for the next pair
      if (state_q == ADD) begin
        sum_q   <= total[WIDTH-1:0];
        cout_q  <= total[WIDTH];
        carry_q <= total[WIDTH];
        and_q   <= &total[WIDTH-1:0];
        or_q    <= |total[WIDTH-1:0];
        xor_q   <= ^total[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_operand_pair_adder.sv
// tb_operand_pair_adder: vector table, hand corner sequences and random pairs against an arithmetic model
module tb_operand_pair_adder;
  logic clk = 0, reset = 1, in_chain = 0, in_valid = 0, out_ready = 0;
  logic [3:0] in_data = '0;
  logic in_ready, out_cout, out_and, out_or, out_xor, out_valid;
  logic [3:0] out_sum;
  int n_pass = 0, n_total = 0;
  int carry = 0;
  typedef struct {
    logic [3:0] a, b;
    logic ch;
    logic [3:0] s;
    logic co, an, o, x;
  } vec_t;
  vec_t tbl[6];

  operand_pair_adder #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_chain(in_chain), .in_valid(in_valid),
    .in_ready(in_ready), .out_sum(out_sum), .out_cout(out_cout), .out_and(out_and),
    .out_or(out_or), .out_xor(out_xor), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send(input logic [3:0] d, input logic c);
    int n = 0;
    in_data = d; in_chain = c; in_valid = 1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic check_result(input string nm, input int s, input int co, input int an, input int o, input int x);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_sum"}, out_sum, s);
    check({nm, "_cout"}, out_cout, co);
    check({nm, "_flags"}, {out_and, out_or, out_xor}, {an[0], o[0], x[0]});
  endtask

  task automatic pair(input string nm, input logic [3:0] a, input logic [3:0] b, input logic ch,
                      input int s, input int co, input int an, input int o, input int x);
    out_ready = 1;
    send(a, ch);
    send(b, 0);
    check({nm, "_busy"}, {in_ready, out_valid}, 0);
    @(negedge clk);
    check_result(nm, s, co, an, o, x);
    @(negedge clk);
    check({nm, "_done"}, {in_ready, out_valid}, 2);
    check({nm, "_kept"}, out_sum, s);
    carry = co;
  endtask

  initial begin
    int a, b, ch, tot, s;
    tbl[0] = '{4'b1010, 4'b1010, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{4'b0001, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{4'b1000, 4'b1001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1};
    in_valid = 1;
    out_ready = 1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", {out_sum, out_cout, out_and, out_or, out_xor}, 0);
    reset = 0;
    in_valid = 0;
    for (int i = 0; i < 6; i++)
      pair($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ch, tbl[i].s, tbl[i].co, tbl[i].an, tbl[i].o, tbl[i].x);
    // backpressure with a word waiting upstream
    out_ready = 0;
    send(4'b0111, 0);
    send(4'b0001, 0);
    in_valid = 1; in_data = 4'b1111; in_chain = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_result("bp", 8, 0, 0, 1, 1);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    check("bp_release", {in_ready, out_valid}, 2);
    @(negedge clk);
    in_valid = 0;
    check("bp_held_word_taken", {in_ready, out_valid}, 2);
    send(4'b0000, 0);
    @(negedge clk);
    check_result("bp_next", 15, 0, 1, 1, 0);
    @(negedge clk);
    carry = 0;
    // reset mid-pair discards A
    send(4'b0110, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rstmid_state", {in_ready, out_valid}, 2);
    pair("rstmid", 4'b0011, 4'b0001, 0, 4, 0, 0, 1, 1);
    // reset with a pending result clears carry_store
    out_ready = 0;
    send(4'b1111, 0);
    send(4'b0001, 0);
    @(negedge clk);
    check_result("pend", 0, 1, 0, 0, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("pend_rst_state", {in_ready, out_valid}, 2);
    check("pend_rst_outs", {out_sum, out_cout}, 0);
    carry = 0;
    pair("pend_chain", 4'b0000, 4'b0000, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      ch = $urandom_range(0, 1);
      tot = a + b + (ch ? carry : 0);
      s = tot % 16;
      pair($sformatf("rnd%0d", i), a[3:0], b[3:0], ch[0], s, tot >= 16 ? 1 : 0,
           s == 15 ? 1 : 0, s != 0 ? 1 : 0, $countones(s) % 2);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
